mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory between the instruction-fetch stage and the EX stage of the 8-bit pipelined processor. The EX control decoder's MemRead/MemWrite and the fetch unit's request are arbitrated here. The arbiter sequences a fixed-latency memory access and returns read data with a one-cycle ack. It also produces the stall signals that freeze the losing pipeline stage.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_priority.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---- mem_arb_pkg : shared types for the memory-port arbiter (rev 1.0) ----
`default_nettype none

package mem_arb_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_EX = 1'b1
  } owner_e;
endpackage

`default_nettype wire

// File: rtl/mem_arb_priority.sv
// ---- mem_arb_priority : IF/EX grant select, optional starvation guard (rev 1.0) ----
// ---- MEMARB_STARVE_GUARD_EN enables the EX streak counter ----
`default_nettype none

module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req_i,
  input  logic ex_req_i,
  input  logic grant_stb_i,
  output logic grant_ex_o,
  output logic grant_if_o
);

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int STRK_W = $clog2(MAX_DATA_STREAK + 2);

  logic [STRK_W-1:0] streak_q, streak_d;
  logic              force_if;

  // Streak never passes MAX_DATA_STREAK: once there with fetch waiting, fetch wins.
  assign force_if   = if_req_i && (streak_q == STRK_W'(MAX_DATA_STREAK));
  assign grant_ex_o = ex_req_i & ~force_if;
  assign grant_if_o = if_req_i & (~ex_req_i | force_if);

  always_comb begin
    streak_d = streak_q;
    if (grant_stb_i) begin
      if (grant_ex_o && if_req_i) streak_d = streak_q + 1'b1;
      else                        streak_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end
`else
  logic unused_nc;

  assign grant_ex_o = ex_req_i;
  assign grant_if_o = if_req_i & ~ex_req_i;
  assign unused_nc  = &{1'b0, clock, reset, grant_stb_i, (MAX_DATA_STREAK > 0)};
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---- mem_port_arbiter : shares one memory port between fetch and EX (rev 1.0) ----
// ---- MEMARB_STARVE_GUARD_EN adds the fetch starvation guard ----
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ex_read,
  input  logic              ex_write,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_ex,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;

  logic ex_req, grant_stb, grant_ex, grant_if, last_cyc;

  assign ex_req    = ex_read | ex_write;
  assign grant_stb = (state_q == IDLE) & (if_req | ex_req);
  assign last_cyc  = (cnt_q == CNT_W'(MEM_LAT - 1));

  mem_arb_priority #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_prio (
    .clock       (clock),
    .reset       (reset),
    .if_req_i    (if_req),
    .ex_req_i    (ex_req),
    .grant_stb_i (grant_stb),
    .grant_ex_o  (grant_ex),
    .grant_if_o  (grant_if)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    if_rdata_d = if_rdata_q;
    ex_rdata_d = ex_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_ex) begin
          state_d = ACCESS;
          cnt_d   = '0;
          owner_d = OWN_EX;
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          wr_d    = ex_write;
        end else if (grant_if) begin
          state_d = ACCESS;
          cnt_d   = '0;
          owner_d = OWN_IF;
          addr_d  = if_addr;
          wdata_d = '0;
          wr_d    = 1'b0;
        end
      end
      ACCESS: begin
        if (last_cyc) begin
          state_d = RESP;
          cnt_d   = '0;
          if (!wr_q) begin
            if (owner_q == OWN_EX) ex_rdata_d = mem_rdata;
            else                   if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      if_rdata_q <= '0;
      ex_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      if_rdata_q <= if_rdata_d;
      ex_rdata_q <= ex_rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == ACCESS) & ~wr_q;
  assign mem_we    = (state_q == ACCESS) &  wr_q;
  assign if_ack    = (state_q == RESP) & (owner_q == OWN_IF);
  assign ex_ack    = (state_q == RESP) & (owner_q == OWN_EX);
  assign if_rdata  = if_rdata_q;
  assign ex_rdata  = ex_rdata_q;
  // Stalls are gated by reset so a frozen pipeline cannot outlive a reset.
  assign stall_if  = ~reset & if_req & ~if_ack;
  assign stall_ex  = ~reset & ex_req & ~ex_ack;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---- tb_mem_port_arbiter : directed + randomized check of mem_port_arbiter (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;
  localparam int L    = 3;
  localparam int MAXS = 3;
`ifdef MEMARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       if_req = 1'b0, ex_read = 1'b0, ex_write = 1'b0;
  logic [7:0] if_addr = '0, ex_addr = '0, ex_wdata = '0, mem_rdata = '0;
  logic [7:0] if_rdata, ex_rdata, mem_addr, mem_wdata;
  logic       if_ack, ex_ack, mem_re, mem_we, stall_if, stall_ex, busy;

  int vec  = 0;
  int errs = 0;
  logic [7:0] exp_ex_rd = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .MEM_LAT(L), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ex_read(ex_read), .ex_write(ex_write), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rdata(ex_rdata), .ex_ack(ex_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_ex(stall_ex), .busy(busy)
  );

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = 8'h10; ex_read = 1'b0; ex_write = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    vec++;
    if ({if_ack, ex_ack, mem_re, mem_we, stall_if, stall_ex, busy} !== 7'b0) begin
      errs++; $display("FAIL reset_ctl: got %b want 0000000", {if_ack, ex_ack, mem_re, mem_we, stall_if, stall_ex, busy});
    end
    vec++;
    if ({if_rdata, ex_rdata, mem_addr, mem_wdata} !== 32'h0) begin
      errs++; $display("FAIL reset_data: got %h want 00000000", {if_rdata, ex_rdata, mem_addr, mem_wdata});
    end
    @(posedge clock); #1;
    reset = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 8'h10; mem_rdata = 8'hA5;
    #1;
    vec++;
    if ({stall_if, busy, mem_re} !== 3'b100) begin
      errs++; $display("FAIL fetch_t0: got %b want 100", {stall_if, busy, mem_re});
    end
    for (int k = 1; k <= L + 1; k++) begin
      @(posedge clock); #2;
      vec++;
      if (k <= L) begin
        if ({mem_re, mem_we, mem_addr, stall_if, if_ack} !== {1'b1, 1'b0, 8'h10, 1'b1, 1'b0}) begin
          errs++; $display("FAIL fetch_access k=%0d: got %h want %h", k,
                           {mem_re, mem_we, mem_addr, stall_if, if_ack}, {1'b1, 1'b0, 8'h10, 1'b1, 1'b0});
        end
      end else begin
        if ({if_ack, if_rdata, stall_if, mem_re} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
          errs++; $display("FAIL fetch_ack: got %h want %h", {if_ack, if_rdata, stall_if, mem_re}, {1'b1, 8'hA5, 1'b0, 1'b0});
        end
      end
    end
    if_req = 1'b0;
    @(posedge clock); #2;
    vec++;
    if ({busy, if_ack} !== 2'b00) begin
      errs++; $display("FAIL fetch_idle: got %b want 00", {busy, if_ack});
    end
  endtask

  task automatic test_store();
    @(posedge clock); #1;
    ex_write = 1'b1; ex_addr = 8'h20; ex_wdata = 8'h3C; mem_rdata = 8'hEE;
    for (int k = 1; k <= L + 1; k++) begin
      @(posedge clock); #2;
      vec++;
      if (k <= L) begin
        if ({mem_we, mem_re, mem_addr, mem_wdata, ex_ack} !== {1'b1, 1'b0, 8'h20, 8'h3C, 1'b0}) begin
          errs++; $display("FAIL store_access k=%0d: got %h want %h", k,
                           {mem_we, mem_re, mem_addr, mem_wdata, ex_ack}, {1'b1, 1'b0, 8'h20, 8'h3C, 1'b0});
        end
      end else begin
        if ({ex_ack, mem_we, ex_rdata} !== {1'b1, 1'b0, exp_ex_rd}) begin
          errs++; $display("FAIL store_ack: got %h want %h", {ex_ack, mem_we, ex_rdata}, {1'b1, 1'b0, exp_ex_rd});
        end
      end
    end
    ex_write = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] a1, a2, r1, r2;
    a1 = 8'($urandom); a2 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = a2; ex_read = 1'b1; ex_addr = a1; mem_rdata = r1;
    for (int k = 1; k <= L + 1; k++) begin
      @(posedge clock); #2;
      vec++;
      if (k <= L) begin
        if ({mem_re, mem_we, mem_addr, stall_if, stall_ex} !== {1'b1, 1'b0, a1, 1'b1, 1'b1}) begin
          errs++; $display("FAIL sim_ex_access k=%0d: got %h want %h", k,
                           {mem_re, mem_we, mem_addr, stall_if, stall_ex}, {1'b1, 1'b0, a1, 1'b1, 1'b1});
        end
      end else begin
        if ({ex_ack, if_ack, stall_if, ex_rdata} !== {1'b1, 1'b0, 1'b1, r1}) begin
          errs++; $display("FAIL sim_ex_ack: got %h want %h", {ex_ack, if_ack, stall_if, ex_rdata}, {1'b1, 1'b0, 1'b1, r1});
        end
        exp_ex_rd = r1; ex_read = 1'b0; mem_rdata = r2;
      end
    end
    @(posedge clock); #2;
    vec++;
    if ({busy, stall_if} !== 2'b01) begin
      errs++; $display("FAIL sim_idle: got %b want 01", {busy, stall_if});
    end
    for (int k = 1; k <= L + 1; k++) begin
      @(posedge clock); #2;
      vec++;
      if (k <= L) begin
        if ({mem_re, mem_addr, stall_if} !== {1'b1, a2, 1'b1}) begin
          errs++; $display("FAIL sim_if_access k=%0d: got %h want %h", k, {mem_re, mem_addr, stall_if}, {1'b1, a2, 1'b1});
        end
      end else begin
        if ({if_ack, if_rdata, ex_rdata} !== {1'b1, r2, r1}) begin
          errs++; $display("FAIL sim_if_ack: got %h want %h", {if_ack, if_rdata, ex_rdata}, {1'b1, r2, r1});
        end
      end
    end
    if_req = 1'b0;
  endtask

  task automatic test_streak();
    int s = 0;
    @(posedge clock); #1;
    if_req = 1'b1; ex_read = 1'b1; if_addr = 8'h44; ex_addr = 8'h55;
    for (int n = 0; n < 8; n++) begin
      bit exp_if, got;
      exp_if = GUARD && (s == MAXS);
      s = exp_if ? 0 : s + 1;
      got = 1'b0;
      for (int c = 0; c < L + 3 && !got; c++) begin
        @(posedge clock); #2;
        if (if_ack || ex_ack) got = 1'b1;
      end
      vec++;
      if (!got || ({if_ack, ex_ack} !== {exp_if, ~exp_if})) begin
        errs++; $display("FAIL streak_order n=%0d: got if/ex ack %b%b (seen=%0d) want %b%b", n, if_ack, ex_ack, got, exp_if, ~exp_if);
      end
    end
    if_req = 1'b0; ex_read = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    @(posedge clock); #1;
    ex_read = 1'b1; ex_addr = 8'h77;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    vec++;
    if ({stall_ex, mem_re} !== 2'b01) begin
      errs++; $display("FAIL rst_mid_stall: got %b want 01", {stall_ex, mem_re});
    end
    @(posedge clock); #2;
    vec++;
    if ({busy, mem_re, mem_we, ex_ack, if_ack} !== 5'b0) begin
      errs++; $display("FAIL rst_mid_idle: got %b want 00000", {busy, mem_re, mem_we, ex_ack, if_ack});
    end
    reset = 1'b0; ex_read = 1'b0;
    for (int c = 0; c < L + 2; c++) begin
      @(posedge clock); #2;
      vec++;
      if ({busy, ex_ack, ex_rdata} !== {1'b0, 1'b0, 8'h00}) begin
        errs++; $display("FAIL rst_mid_noack c=%0d: got %h want 000", c, {busy, ex_ack, ex_rdata});
      end
    end
  endtask

  // Reference: an access granted at cycle g occupies cycles g+1..g+L, acks at g+L+1.
  task automatic test_random();
    bit         m_busy = 0, m_ex = 0, m_wr = 0;
    int         m_k = 0, m_streak = 0;
    logic [7:0] m_addr = '0, m_wdata = '0, e_if = '0, e_ex = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit acc, ack, ifa, exa, exr, take_if;
      logic [1:0] op;
      @(posedge clock); #1;
      acc = m_busy && (m_k <= L);
      ack = m_busy && (m_k == L + 1);
      ifa = ack && !m_ex;
      exa = ack && m_ex;
      if (!if_req || ifa) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = 8'($urandom);
      end
      if (!(ex_read || ex_write) || exa) begin
        op = 2'($urandom_range(0, 3));
        ex_read = op[0]; ex_write = op[1]; ex_addr = 8'($urandom); ex_wdata = 8'($urandom);
      end
      mem_rdata = 8'($urandom);
      exr = ex_read || ex_write;
      #1;
      vec++;
      if ({mem_re, mem_we} !== {acc && !m_wr, acc && m_wr}) begin
        errs++; $display("FAIL rnd_en cyc=%0d: got %b%b want %b%b", cyc, mem_re, mem_we, acc && !m_wr, acc && m_wr);
      end
      vec++;
      if ({if_ack, ex_ack, busy} !== {ifa, exa, m_busy}) begin
        errs++; $display("FAIL rnd_ack cyc=%0d: got %b want %b", cyc, {if_ack, ex_ack, busy}, {ifa, exa, m_busy});
      end
      vec++;
      if ({stall_if, stall_ex} !== {if_req && !ifa, exr && !exa}) begin
        errs++; $display("FAIL rnd_stall cyc=%0d: got %b want %b", cyc, {stall_if, stall_ex}, {if_req && !ifa, exr && !exa});
      end
      vec++;
      if ({if_rdata, ex_rdata} !== {e_if, e_ex}) begin
        errs++; $display("FAIL rnd_rdata cyc=%0d: got %h want %h", cyc, {if_rdata, ex_rdata}, {e_if, e_ex});
      end
      if (acc) begin
        vec++;
        if (mem_addr !== m_addr || (m_wr && mem_wdata !== m_wdata)) begin
          errs++; $display("FAIL rnd_addr cyc=%0d: got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, m_addr, m_wdata);
        end
      end
      if (!m_busy) begin
        if (if_req || exr) begin
          take_if = if_req && (!exr || (GUARD && m_streak == MAXS));
          m_busy  = 1'b1; m_k = 1;
          if (take_if) begin
            m_ex = 1'b0; m_addr = if_addr; m_wr = 1'b0; m_streak = 0;
          end else begin
            m_ex = 1'b1; m_addr = ex_addr; m_wdata = ex_wdata; m_wr = ex_write;
            m_streak = if_req ? m_streak + 1 : 0;
          end
        end
      end else begin
        if (m_k == L && !m_wr) begin
          if (m_ex) e_ex = mem_rdata;
          else      e_if = mem_rdata;
        end
        if (m_k == L + 1) m_busy = 1'b0;
        else              m_k++;
      end
    end
    if_req = 1'b0; ex_read = 1'b0; ex_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_streak();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
